// File: rtl/gshare_predictor.sv
// Global-history branch direction predictor (GAg or gshare) with a PHT of saturating counters.
// After reset a sweep FSM writes CTR_INIT into every PHT entry before predictions are accepted.
module gshare_predictor #(
    parameter int HIST_W    = 12,
    parameter int IDX_W     = 12,
    parameter int CTR_W     = 2,
    parameter int HASH_MODE = 1,
    parameter int CTR_INIT  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Pred_valid_IN,
    input  logic [31:0]       Pred_addr_IN,
    output logic              Pred_valid_OUT,
    output logic              Taken,
    output logic [IDX_W-1:0]  Pred_index_OUT,
    input  logic              Upd_valid_IN,
    input  logic [IDX_W-1:0]  Upd_index_IN,
    input  logic              Upd_taken_IN,
    output logic              Ready,
    output logic [HIST_W-1:0] Ghr_OUT
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_next;
    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_next;
    logic [IDX_W-1:0]  ghr_ext;
    logic [IDX_W-1:0]  pred_idx;
    logic [CTR_W-1:0]  pht [DEPTH];
    logic [CTR_W-1:0]  pred_ctr;
    logic [CTR_W-1:0]  upd_ctr;
    logic [CTR_W-1:0]  upd_ctr_next;
    logic              unused_pc_bits;

    // Sweep FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Sweep FSM: next state
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            ST_INIT: begin
                ptr_next = ptr + IDX_W'(1);
                if (ptr == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign Ready   = (state == ST_RUN);
    assign Ghr_OUT = ghr;
    assign ghr_ext = IDX_W'(ghr);

    generate
        if (HASH_MODE != 0) begin : g_gshare
            assign pred_idx = Pred_addr_IN[IDX_W+1:2] ^ ghr_ext;
        end else begin : g_gag
            assign pred_idx = ghr_ext;
        end

        if (HIST_W == 1) begin : g_ghr_one
            assign ghr_next = Upd_taken_IN;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[HIST_W-2:0], Upd_taken_IN};
        end
    endgenerate

    assign unused_pc_bits = ^{Pred_addr_IN[31:IDX_W+2], Pred_addr_IN[1:0]};

    // Two asynchronous read ports: one for the prediction, one for the training read-modify-write.
    assign pred_ctr = pht[pred_idx];
    assign upd_ctr  = pht[Upd_index_IN];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (Upd_taken_IN) begin
            if (upd_ctr != {CTR_W{1'b1}}) begin
                upd_ctr_next = upd_ctr + CTR_W'(1);
            end
        end else begin
            if (upd_ctr != '0) begin
                upd_ctr_next = upd_ctr - CTR_W'(1);
            end
        end
    end

    // Single PHT write port shared by the init sweep and the training path.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == ST_INIT) begin
                pht[ptr] <= CTR_W'(CTR_INIT);
            end else if (Upd_valid_IN) begin
                pht[Upd_index_IN] <= upd_ctr_next;
            end
        end
    end

    // The prediction samples pred_ctr before any same-edge PHT write lands (read-before-write).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Pred_valid_OUT <= 1'b0;
            Taken          <= 1'b0;
            Pred_index_OUT <= '0;
            ghr            <= '0;
        end else if (state == ST_RUN) begin
            Pred_valid_OUT <= Pred_valid_IN;
            if (Pred_valid_IN) begin
                Taken          <= pred_ctr[CTR_W-1];
                Pred_index_OUT <= pred_idx;
            end else begin
                Taken <= 1'b0;
            end
            if (Upd_valid_IN) begin
                ghr <= ghr_next;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a gshare instance plus a GAg instance on the same inputs.
module tb_gshare_predictor;

    logic        CLK;
    logic        RESET;
    logic        Pred_valid_IN;
    logic [31:0] Pred_addr_IN;
    logic        Upd_valid_IN;
    logic [11:0] Upd_index_IN;
    logic        Upd_taken_IN;

    logic        pv_g, tk_g, rdy_g;
    logic [11:0] pi_g, ghr_g;
    logic        pv_a, tk_a, rdy_a;
    logic [11:0] pi_a, ghr_a;

    int pass_cnt = 0;
    int total_cnt = 0;

    gshare_predictor #(.HASH_MODE(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .Pred_valid_IN(Pred_valid_IN), .Pred_addr_IN(Pred_addr_IN),
        .Pred_valid_OUT(pv_g), .Taken(tk_g), .Pred_index_OUT(pi_g),
        .Upd_valid_IN(Upd_valid_IN), .Upd_index_IN(Upd_index_IN), .Upd_taken_IN(Upd_taken_IN),
        .Ready(rdy_g), .Ghr_OUT(ghr_g)
    );

    gshare_predictor #(.HASH_MODE(0)) dut_gag (
        .CLK(CLK), .RESET(RESET),
        .Pred_valid_IN(Pred_valid_IN), .Pred_addr_IN(Pred_addr_IN),
        .Pred_valid_OUT(pv_a), .Taken(tk_a), .Pred_index_OUT(pi_a),
        .Upd_valid_IN(Upd_valid_IN), .Upd_index_IN(Upd_index_IN), .Upd_taken_IN(Upd_taken_IN),
        .Ready(rdy_a), .Ghr_OUT(ghr_a)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        upd;
        logic [11:0] uidx;
        logic        ut;
        logic        ev;
        logic        et;
        logic [11:0] ei;
        logic [11:0] eg;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input logic req, input logic [31:0] pc, input logic upd,
                           input logic [11:0] uidx, input logic ut, input logic ev,
                           input logic et, input logic [11:0] ei, input logic [11:0] eg);
        vecs[i].req = req; vecs[i].pc = pc; vecs[i].upd = upd; vecs[i].uidx = uidx;
        vecs[i].ut = ut; vecs[i].ev = ev; vecs[i].et = et; vecs[i].ei = ei; vecs[i].eg = eg;
    endtask

    // Driver: called at a negedge, returns at the next negedge with inputs idle.
    task automatic step(input logic req, input logic [31:0] pc, input logic upd,
                        input logic [11:0] uidx, input logic ut);
        Pred_valid_IN = req; Pred_addr_IN = pc;
        Upd_valid_IN = upd; Upd_index_IN = uidx; Upd_taken_IN = ut;
        @(negedge CLK);
        Pred_valid_IN = 1'b0; Pred_addr_IN = '0;
        Upd_valid_IN = 1'b0; Upd_index_IN = '0; Upd_taken_IN = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Counts negedge samples with Ready=0; inputs are held busy to show they are ignored.
    task automatic wait_sweep(input string name);
        int cnt = 0;
        int leak = 0;
        Pred_valid_IN = 1'b1; Pred_addr_IN = 32'h0040_0010;
        Upd_valid_IN = 1'b1; Upd_index_IN = 12'h004; Upd_taken_IN = 1'b1;
        while (rdy_g !== 1'b1 && cnt < 6000) begin
            if (pv_g !== 1'b0 || ghr_g !== 12'h000 || pv_a !== 1'b0) leak++;
            cnt++;
            @(negedge CLK);
        end
        Pred_valid_IN = 1'b0; Upd_valid_IN = 1'b0; Upd_taken_IN = 1'b0;
        check({name, "_ready_cycles"}, cnt, 4096);
        check({name, "_ignored_in_init"}, leak, 0);
        check({name, "_gag_ready"}, rdy_a, 1);
    endtask

    initial begin
        RESET = 1'b1;
        Pred_valid_IN = 1'b0; Pred_addr_IN = '0;
        Upd_valid_IN = 1'b0; Upd_index_IN = '0; Upd_taken_IN = 1'b0;

        // Cold prediction then saturation at idx 0x004; PCs chosen so PC[13:2]^GHR = 0x004.
        set_vec(0,  1, 32'h0040_0010, 0, 12'h000, 0, 1, 0, 12'h004, 12'h000);
        set_vec(1,  0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h001);
        set_vec(2,  0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h003);
        set_vec(3,  0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h007);
        set_vec(4,  0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h00F);
        set_vec(5,  0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h01F);
        set_vec(6,  1, 32'h0040_006C, 0, 12'h000, 0, 1, 1, 12'h004, 12'h01F);
        set_vec(7,  0, 32'h0,         1, 12'h004, 0, 0, 0, 12'h004, 12'h03E);
        set_vec(8,  1, 32'h0040_00E8, 0, 12'h000, 0, 1, 1, 12'h004, 12'h03E);
        set_vec(9,  0, 32'h0,         1, 12'h004, 0, 0, 0, 12'h004, 12'h07C);
        set_vec(10, 0, 32'h0,         1, 12'h004, 0, 0, 0, 12'h004, 12'h0F8);
        set_vec(11, 0, 32'h0,         1, 12'h004, 0, 0, 0, 12'h004, 12'h1F0);
        set_vec(12, 1, 32'h0040_07D0, 0, 12'h000, 0, 1, 0, 12'h004, 12'h1F0);
        set_vec(13, 0, 32'h0,         1, 12'h004, 0, 0, 0, 12'h004, 12'h3E0);
        set_vec(14, 1, 32'h0040_0F90, 0, 12'h000, 0, 1, 0, 12'h004, 12'h3E0);
        set_vec(15, 0, 32'h0,         1, 12'h004, 1, 0, 0, 12'h004, 12'h7C1);
        set_vec(16, 1, 32'h0040_1F14, 0, 12'h000, 0, 1, 0, 12'h004, 12'h7C1);

        // Reset sweep
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_valid", pv_g, 0);
        check("rst_taken", tk_g, 0);
        check("rst_index", pi_g, 0);
        check("rst_ghr", ghr_g, 0);
        check("rst_ready", rdy_g, 0);
        wait_sweep("sweep1");

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].req, vecs[i].pc, vecs[i].upd, vecs[i].uidx, vecs[i].ut);
            check($sformatf("vec%0d_valid", i), pv_g, vecs[i].ev);
            check($sformatf("vec%0d_taken", i), tk_g, vecs[i].et);
            check($sformatf("vec%0d_index", i), pi_g, vecs[i].ei);
            check($sformatf("vec%0d_ghr", i), ghr_g, vecs[i].eg);
        end

        // GHR and hash: fresh table, T,N,T updates away from idx 0x004
        pulse_reset();
        wait_sweep("sweep2");
        step(0, 32'h0, 1, 12'h100, 1);
        step(0, 32'h0, 1, 12'h101, 0);
        step(0, 32'h0, 1, 12'h102, 1);
        check("hist_ghr", ghr_g, 12'h005);
        check("hist_ghr_gag", ghr_a, 12'h005);
        step(1, 32'h0040_0014, 0, 12'h000, 0);
        check("hash_index", pi_g, 12'h000);
        check("hash_taken", tk_g, 0);
        check("gag_index", pi_a, 12'h005);
        check("gag_valid", pv_a, 1);

        // Collision: request and taken update on idx 0x004 in the same cycle
        step(1, 32'h0040_0004, 1, 12'h004, 1);
        check("coll_index", pi_g, 12'h004);
        check("coll_taken_old", tk_g, 0);
        check("coll_ghr", ghr_g, 12'h00B);
        step(1, 32'h0040_003C, 0, 12'h000, 0);
        check("coll_index_next", pi_g, 12'h004);
        check("coll_taken_new", tk_g, 1);
        step(0, 32'h0, 0, 12'h000, 0);
        check("idle_valid", pv_g, 0);
        check("idle_taken", tk_g, 0);
        check("idle_index_hold", pi_g, 12'h004);

        // Reset in RUN with a request pending, then again at sweep ptr 0x800
        Pred_valid_IN = 1'b1; Pred_addr_IN = 32'h0040_003C;
        pulse_reset();
        Pred_valid_IN = 1'b0;
        check("run_rst_valid", pv_g, 0);
        check("run_rst_index", pi_g, 0);
        check("run_rst_ghr", ghr_g, 0);
        check("run_rst_ready", rdy_g, 0);
        repeat (12'h800) @(negedge CLK);
        check("mid_rst_ready", rdy_g, 0);
        pulse_reset();
        wait_sweep("sweep3");
        check("post_rst_ghr", ghr_g, 0);
        step(1, 32'h0040_0010, 0, 12'h000, 0);
        check("post_rst_idx4_taken", tk_g, 0);
        step(1, 32'h0040_0400, 0, 12'h000, 0);
        check("post_rst_idx100_index", pi_g, 12'h100);
        check("post_rst_idx100_taken", tk_g, 0);
        step(0, 32'h0, 1, 12'h004, 1);
        step(1, 32'h0040_0014, 0, 12'h000, 0);
        check("post_rst_ctr01_index", pi_g, 12'h004);
        check("post_rst_ctr01_taken", tk_g, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
